// File: rtl/sram22_arb2_pkg.sv
// Shared widths, port ids and request record for the two-port sram22 arbiter.
// Defaults match the 4096x8 sram22 macro with a single write-mask bit.
package sram22_arb_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int ADDR_WIDTH  = 12;
    localparam int WMASK_WIDTH = 1;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram22_arb2_if.sv
// One client port: valid/ready request channel plus valid/ready read-response channel.
// master = requesting client, slave = arbiter.
interface sram22_arb2_if;
    import sram22_arb_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    req_t                  req;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/sram22_resp_slot.sv
// Per-port read tracker: pending flag for the in-flight macro read and a one-entry response register.
// Latency: captures sram_dout the cycle after issue; holds rdata while resp_valid && !resp_ready.
module sram22_resp_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    input  logic                  resp_ready,
    output logic                  pend,
    output logic                  free,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata
);

    // Slot can take a new read if it is empty or being drained on this edge.
    assign free = !resp_valid || resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            pend <= issue;
            if (pend) begin
                resp_valid <= 1'b1;
                resp_rdata <= sram_dout;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sram22_arb2.sv
// Round-robin arbiter putting two valid/ready clients onto one single-port sram22 macro.
// Latency: read handshake -> resp_valid 2 cycles; reads stall while the port's response is unconsumed.
module sram22_arb2 #(
    parameter int DATA_WIDTH  = sram22_arb_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = sram22_arb_pkg::ADDR_WIDTH,
    parameter int WMASK_WIDTH = sram22_arb_pkg::WMASK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram22_arb2_if.slave           a,
    sram22_arb2_if.slave           b,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    import sram22_arb_pkg::*;

    port_id_t rr_ptr;
    logic     a_pend, a_free, b_pend, b_free;
    logic     a_elig, b_elig;
    logic     grant_a, grant_b;
    req_t     sel;

    // Writes need no response slot; reads need an idle pipeline and room for the result.
    assign a_elig = a.req_valid && (a.req.we || (!a_pend && a_free));
    assign b_elig = b.req_valid && (b.req.we || (!b_pend && b_free));

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n) begin
            if (a_elig && b_elig) begin
                grant_a = (rr_ptr == PORT_B);
                grant_b = (rr_ptr == PORT_A);
            end else begin
                grant_a = a_elig;
                grant_b = b_elig;
            end
        end
    end

    assign a.req_ready = grant_a;
    assign b.req_ready = grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= PORT_A;
        end else if (grant_a) begin
            rr_ptr <= PORT_A;
        end else if (grant_b) begin
            rr_ptr <= PORT_B;
        end
    end

    // Idle cycles present a harmless read of address 0.
    always_comb begin
        sel = '0;
        if (grant_a) begin
            sel = a.req;
        end else if (grant_b) begin
            sel = b.req;
        end
    end

    assign sram_we    = sel.we;
    assign sram_addr  = sel.addr;
    assign sram_din   = sel.wdata;
    assign sram_wmask = '1;

    sram22_resp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (grant_a && !a.req.we),
        .sram_dout  (sram_dout),
        .resp_ready (a.resp_ready),
        .pend       (a_pend),
        .free       (a_free),
        .resp_valid (a.resp_valid),
        .resp_rdata (a.resp_rdata)
    );

    sram22_resp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (grant_b && !b.req.we),
        .sram_dout  (sram_dout),
        .resp_ready (b.resp_ready),
        .pend       (b_pend),
        .free       (b_free),
        .resp_valid (b.resp_valid),
        .resp_rdata (b.resp_rdata)
    );

endmodule
